// File: rtl/isa_pkg.sv
// Instruction-set definitions shared by the decode stage and its register file:
// field positions, opcode names and per-opcode operand/destination usage.
package isa_pkg;

  localparam int DATA_W = 32;
  localparam int PC_W   = 8;
  localparam int IMM_W  = 16;
  localparam int NREG   = 8;
  localparam int RIDX_W = 3;

  localparam int COND_LSB = 28;
  localparam int OP_LSB   = 24;
  localparam int S_BIT    = 23;
  localparam int RD_LSB   = 20;
  localparam int RN_LSB   = 17;
  localparam int I_BIT    = 16;
  localparam int IMM_LSB  = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_ORR  = 4'h3,
    OP_AND  = 4'h4,
    OP_XOR  = 4'h5,
    OP_MOVN = 4'h6,
    OP_MOV  = 4'h7,
    OP_LSR  = 4'h8,
    OP_LSL  = 4'h9,
    OP_ROR  = 4'hA,
    OP_CMP  = 4'hB,
    OP_ADR  = 4'hC,
    OP_LDR  = 4'hD,
    OP_STR  = 4'hE,
    OP_NOP  = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [3:0]        cond;
    opcode_e           op;
    logic              s;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rn;
    logic [RIDX_W-1:0] rm;
    logic              i;
    logic [IMM_W-1:0]  imm;
  } instr_t;

  // rm overlaps the low immediate bits; it is only meaningful when i=0.
  function automatic instr_t split_instr(input logic [31:0] w);
    instr_t f;
    f.cond = w[COND_LSB +: 4];
    f.op   = opcode_e'(w[OP_LSB +: 4]);
    f.s    = w[S_BIT];
    f.rd   = w[RD_LSB +: RIDX_W];
    f.rn   = w[RN_LSB +: RIDX_W];
    f.i    = w[I_BIT];
    f.imm  = w[IMM_LSB +: IMM_W];
    f.rm   = w[IMM_LSB +: RIDX_W];
    return f;
  endfunction

  function automatic logic writes_rd(input opcode_e op);
    return !(op inside {OP_CMP, OP_STR, OP_NOP});
  endfunction

  function automatic logic reads_rn(input opcode_e op);
    return !(op inside {OP_MOVN, OP_NOP});
  endfunction

  function automatic logic reads_rm(input opcode_e op, input logic i);
    return !i && !(op inside {OP_MOV, OP_MOVN, OP_NOP});
  endfunction

endpackage

// File: rtl/regfile_8x32.sv
// 8x32 architectural register file: three combinational read ports with
// same-cycle writeback bypass, one clocked write port.
module regfile_8x32
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [RIDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [RIDX_W-1:0] addr_a,
  input  logic [RIDX_W-1:0] addr_b,
  input  logic [RIDX_W-1:0] addr_c,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] data_c
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // A writeback landing this cycle is visible to readers in the same cycle.
  assign data_a = (wb_en && wb_addr == addr_a) ? wb_data : regs[addr_a];
  assign data_b = (wb_en && wb_addr == addr_b) ? wb_data : regs[addr_b];
  assign data_c = (wb_en && wb_addr == addr_c) ? wb_data : regs[addr_c];

endmodule

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage ahead of the ALU: splits the instruction, reads
// operands, tracks pending destination writes and stalls on RAW hazards.
module decode_stage
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              wb_en,
  input  logic [RIDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        op_code,
  output logic [3:0]        conditions,
  output logic              s,
  output logic [IMM_W-1:0]  immediate_value,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] store_data,
  output logic [RIDX_W-1:0] dest,
  output logic              dest_we,
  output logic [PC_W-1:0]   out_pc,
  output logic [NREG-1:0]   busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Upstream: in_ready never depends on in_valid. Downstream: once out_valid
  // is raised the whole bundle stays frozen until out_ready is seen high.

  instr_t            f;
  logic [DATA_W-1:0] rn_data;
  logic [DATA_W-1:0] rm_data;
  logic [DATA_W-1:0] rd_data;
  logic [NREG-1:0]   wb_mask;
  logic [NREG-1:0]   busy_eff;
  logic [NREG-1:0]   set_mask;
  logic              hazard;
  logic              accept;

  assign f = split_instr(in_instr);

  regfile_8x32 u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .addr_a  (f.rn),
    .addr_b  (f.rm),
    .addr_c  (f.rd),
    .data_a  (rn_data),
    .data_b  (rm_data),
    .data_c  (rd_data)
  );

  // A register whose writeback arrives this cycle is no longer pending.
  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (wb_en) wb_mask = NREG'(1) << wb_addr;
    busy_eff = busy & ~wb_mask;
    hazard   = (reads_rn(f.op) && busy_eff[f.rn]) ||
               (reads_rm(f.op, f.i) && busy_eff[f.rm]) ||
               ((f.op == OP_STR) && busy_eff[f.rd]);
    in_ready = reset && !hazard && (!out_valid || out_ready) && !flush;
    accept   = in_valid && in_ready;
    if (accept && writes_rd(f.op)) set_mask = NREG'(1) << f.rd;
  end

  // Set is OR-ed after the writeback clear so a same-edge set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= busy_eff | set_mask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid       <= 1'b0;
      op_code         <= '0;
      conditions      <= '0;
      s               <= 1'b0;
      immediate_value <= '0;
      src1            <= '0;
      src2            <= '0;
      store_data      <= '0;
      dest            <= '0;
      dest_we         <= 1'b0;
      out_pc          <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      op_code         <= f.op;
      conditions      <= f.cond;
      s               <= f.s;
      immediate_value <= f.imm;
      src1            <= rn_data;
      src2            <= f.i ? '0 : rm_data;
      store_data      <= (f.op == OP_STR) ? rd_data : '0;
      dest            <= f.rd;
      dest_we         <= writes_rd(f.op);
      out_pc          <= in_pc;
    end else if (out_ready) begin
      // Drain: data fields keep their last value.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic, compared
// against a cycle-level behavioural model of the register file and scoreboard.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_pc;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  op_code;
  logic [3:0]  conditions;
  logic        s;
  logic [15:0] immediate_value;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] store_data;
  logic [2:0]  dest;
  logic        dest_we;
  logic [7:0]  out_pc;
  logic [7:0]  busy;

  decode_stage dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .op_code         (op_code),
    .conditions      (conditions),
    .s               (s),
    .immediate_value (immediate_value),
    .src1            (src1),
    .src2            (src2),
    .store_data      (store_data),
    .dest            (dest),
    .dest_we         (dest_we),
    .out_pc          (out_pc),
    .busy            (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  cond;
    logic        s;
    logic [15:0] imm;
    logic [2:0]  dest;
    logic        we;
    logic [7:0]  pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] store;
  } bundle_t;

  logic [31:0]  m_reg [8];
  bit           m_busy [8];
  bit           m_valid;
  bundle_t      m_b;
  logic [132:0] exp_q [$];

  int   checks = 0;
  int   errors = 0;
  logic last_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [3:0] op,
                                     input logic sb, input logic [2:0] rd,
                                     input logic [2:0] rn, input logic ib,
                                     input logic [15:0] imm);
    return {cond, op, sb, rd, rn, ib, imm};
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] r);
    return (wb_en && wb_addr == r) ? wb_data : m_reg[r];
  endfunction

  // Registers the instruction must see settled before it may issue.
  function automatic bit m_ready();
    int          need [$];
    logic [3:0]  op = in_instr[27:24];
    if (!(op == 4'h6 || op == 4'hF)) need.push_back(int'(in_instr[19:17]));
    if (!in_instr[16] && !(op inside {4'h6, 4'h7, 4'hF})) need.push_back(int'(in_instr[2:0]));
    if (op == 4'hE) need.push_back(int'(in_instr[22:20]));
    foreach (need[k])
      if (m_busy[need[k]] && !(wb_en && int'(wb_addr) == need[k])) return 1'b0;
    if (m_valid && !out_ready) return 1'b0;
    if (flush) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] busy_vec();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_busy[k];
    return v;
  endfunction

  function automatic logic [132:0] pack_exp(input bundle_t b);
    return {b.op, b.cond, b.s, b.imm, b.dest, b.we, b.pc, b.src1, b.src2, b.store};
  endfunction

  function automatic logic [132:0] dut_pack();
    return {op_code, conditions, s, immediate_value, dest, dest_we, out_pc,
            src1, src2, store_data};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_reg[k]  = '0;
      m_busy[k] = 1'b0;
    end
    m_valid = 1'b0;
    m_b     = '0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard (mid-cycle) ----------------
  task automatic check_cycle();
    logic [132:0] d;
    logic [132:0] e;
    last_ready = in_ready;
    check("in_ready", in_ready, m_ready());
    check("out_valid", out_valid, m_valid);
    check("busy", busy, busy_vec());
    d = dut_pack();
    e = pack_exp(m_b);
    check("ctrl", d[132:96], e[132:96]);
    check("src1", d[95:64], e[95:64]);
    check("src2", d[63:32], e[63:32]);
    check("store", d[31:0], e[31:0]);
    if (out_valid && out_ready && !flush) begin
      check("q_size", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q_ctrl", d[132:96], e[132:96]);
        check("q_src1", d[95:64], e[95:64]);
        check("q_src2", d[63:32], e[63:32]);
        check("q_store", d[31:0], e[31:0]);
      end
    end
  endtask

  // ---------------- model update (at the edge) ----------------
  task automatic model_update();
    bit         acc = in_valid && m_ready();
    logic [3:0] op  = in_instr[27:24];
    bit         we  = !(op inside {4'hB, 4'hE, 4'hF});
    if (flush) exp_q.delete();
    if (acc) begin
      m_b.op    = op;
      m_b.cond  = in_instr[31:28];
      m_b.s     = in_instr[23];
      m_b.imm   = in_instr[15:0];
      m_b.dest  = in_instr[22:20];
      m_b.we    = we;
      m_b.pc    = in_pc;
      m_b.src1  = m_read(in_instr[19:17]);
      m_b.src2  = in_instr[16] ? 32'd0 : m_read(in_instr[2:0]);
      m_b.store = (op == 4'hE) ? m_read(in_instr[22:20]) : 32'd0;
      exp_q.push_back(pack_exp(m_b));
      m_valid = 1'b1;
    end else if (flush || out_ready) begin
      m_valid = 1'b0;
    end
    if (flush) begin
      for (int k = 0; k < 8; k++) m_busy[k] = 1'b0;
    end else begin
      if (wb_en) m_busy[wb_addr] = 1'b0;
      if (acc && we) m_busy[in_instr[22:20]] = 1'b1;
    end
    if (wb_en) m_reg[wb_addr] = wb_data;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [31:0] ins, input logic [7:0] pc,
                      input logic we, input logic [2:0] wa, input logic [31:0] wd,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    wb_en     = we;
    wb_addr   = wa;
    wb_data   = wd;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  logic [31:0] add_3_1_2;
  logic [31:0] sub_4_3_1;
  logic [31:0] and_6_1_2;
  logic [31:0] str_5_6;

  initial begin
    add_3_1_2 = mk(4'h0, 4'h0, 1'b0, 3'd3, 3'd1, 1'b0, 16'd2);
    sub_4_3_1 = mk(4'h0, 4'h1, 1'b0, 3'd4, 3'd3, 1'b0, 16'd1);
    and_6_1_2 = mk(4'h0, 4'h4, 1'b0, 3'd6, 3'd1, 1'b0, 16'd2);
    str_5_6   = mk(4'h0, 4'hE, 1'b0, 3'd5, 3'd6, 1'b1, 16'd0);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_bundle", {src1, out_pc, op_code, dest_we}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    // Basic ADD after two writebacks.
    step(0, '0, 8'h00, 1, 3'd1, 32'd5, 1, 0);
    step(0, '0, 8'h00, 1, 3'd2, 32'd7, 1, 0);
    step(1, add_3_1_2, 8'h10, 0, 3'd0, 32'd0, 1, 0);
    check("t1_valid", out_valid, 1);
    check("t1_src1", src1, 5);
    check("t1_src2", src2, 7);
    check("t1_dest", dest, 3);
    check("t1_we", dest_we, 1);
    check("t1_op", op_code, 0);

    // RAW on r3, released by a same-cycle writeback.
    step(1, sub_4_3_1, 8'h11, 0, 3'd0, 32'd0, 1, 0);
    check("t2_stall", last_ready, 0);
    step(1, sub_4_3_1, 8'h11, 1, 3'd3, 32'd12, 1, 0);
    check("t2_issue", last_ready, 1);
    check("t2_src1", src1, 12);
    check("t2_src2", src2, 5);
    check("t2_op", op_code, 1);

    // Output hold for three cycles.
    step(0, '0, 8'h00, 0, 3'd0, 32'd0, 1, 0);
    step(1, mk(4'h0, 4'h3, 1'b0, 3'd5, 3'd1, 1'b0, 16'd2), 8'h20, 0, 3'd0, 32'd0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, and_6_1_2, 8'h21, 0, 3'd0, 32'd0, 0, 0);
      check("t3_hold_rdy", last_ready, 0);
      check("t3_hold_pc", out_pc, 8'h20);
    end
    step(1, and_6_1_2, 8'h21, 0, 3'd0, 32'd0, 1, 0);
    check("t3_next_pc", out_pc, 8'h21);

    // MOVN immediate, then CMP (no destination).
    step(1, mk(4'h0, 4'h6, 1'b0, 3'd2, 3'd0, 1'b1, 16'd1126), 8'h30, 0, 3'd0, 32'd0, 1, 0);
    check("t4_imm", immediate_value, 1126);
    check("t4_src2", src2, 0);
    check("t4_op", op_code, 6);
    step(1, mk(4'h0, 4'hB, 1'b1, 3'd0, 3'd1, 1'b0, 16'd2), 8'h31, 1, 3'd2, 32'h99, 1, 0);
    check("t4_cmp_we", dest_we, 0);
    check("t4_cmp_src2", src2, 32'h99);
    check("t4_busy", busy, 8'b0111_0000);

    // STR waits on its data register.
    step(1, mk(4'h0, 4'h0, 1'b0, 3'd5, 3'd1, 1'b0, 16'd1), 8'h40, 1, 3'd6, 32'h66, 1, 0);
    step(1, str_5_6, 8'h41, 0, 3'd0, 32'd0, 1, 0);
    check("t5_stall", last_ready, 0);
    step(1, str_5_6, 8'h41, 1, 3'd5, 32'hDEADBEEF, 1, 0);
    check("t5_store", store_data, 32'hDEADBEEF);
    check("t5_src1", src1, 32'h66);
    check("t5_we", dest_we, 0);

    // Flush while holding a bundle with pending destinations.
    step(1, add_3_1_2, 8'h50, 0, 3'd0, 32'd0, 1, 0);
    step(0, '0, 8'h00, 0, 3'd0, 32'd0, 0, 1);
    check("t6_flush_valid", out_valid, 0);
    check("t6_flush_busy", busy, 0);
    check("t6_flush_pc", out_pc, 8'h50);

    // Asynchronous reset in the middle of a hold.
    step(1, add_3_1_2, 8'h60, 0, 3'd0, 32'd0, 1, 0);
    step(0, '0, 8'h00, 0, 3'd0, 32'd0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("rr_valid", out_valid, 0);
    check("rr_src1", src1, 0);
    check("rr_pc", out_pc, 0);
    check("rr_busy", busy, 0);
    check("rr_ready", in_ready, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    step(1, add_3_1_2, 8'h70, 0, 3'd0, 32'd0, 1, 0);
    check("rr_regs", src1, 0);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      logic [31:0] ins;
      logic [2:0]  wa;
      int          pend [$];
      ins = mk(4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
               1'($urandom), 16'($urandom));
      for (int k = 0; k < 8; k++) if (m_busy[k]) pend.push_back(k);
      wa = 3'($urandom);
      if (pend.size() > 0 && $urandom_range(0, 1) == 1)
        wa = 3'(pend[$urandom_range(0, pend.size() - 1)]);
      step($urandom_range(0, 3) != 0, ins, 8'($urandom), 1'($urandom), wa, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
